// File: rtl/rr_arbiter10.sv
// rr_arbiter10: 10-way round-robin arbiter with registered grant, binary index and hold-timeout watchdog.
module rr_arbiter10 #(
    parameter int N       = 10,
    parameter int IDXW    = 4,
    parameter int MAXHOLD = 16
) (
    input  logic            iCLK,
    input  logic            iRSTn,
    input  logic [N-1:0]    iREQ,
    input  logic            iDONE,
    output logic [N-1:0]    oGNT,
    output logic [IDXW-1:0] oGNT_IDX,
    output logic            oVALID,
    output logic            oTIMEOUT
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state_q, state_d;
    logic [N-1:0] gnt_q, gnt_d;
    logic [IDXW-1:0] idx_q, idx_d, ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic tmo_q, tmo_d;
    logic expired, rel;
    logic [N-1:0] req_m, rot;
    logic [IDXW-1:0] k, sel;
    logic found;
    logic [IDXW:0] sum;
    always_comb begin
        expired = cnt_q == 8'(MAXHOLD - 1);
        rel = state_q == GRANT && (iDONE || !(|(iREQ & gnt_q)) || expired);
        tmo_d = rel && expired && !iDONE;
        ptr_d = rel ? (idx_q == 4'd9 ? 4'd0 : idx_q + 4'd1) : ptr_q;
        req_m = rel ? iREQ & ~gnt_q : iREQ;
        // rotate so bit 0 is the highest-priority requester, then take the first set bit
        rot = N'({req_m, req_m} >> ptr_d);
        k = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                k = 4'(i);
                found = 1'b1;
            end
        end
        sum = {1'b0, ptr_d} + {1'b0, k};
        sel = sum >= 5'd10 ? 4'(sum - 5'd10) : sum[3:0];
        state_d = state_q;
        gnt_d = gnt_q;
        idx_d = idx_q;
        cnt_d = state_q == GRANT ? cnt_q + 8'd1 : cnt_q;
        if ((state_q == IDLE || rel) && found) begin
            state_d = GRANT;
            gnt_d = N'(1) << sel;
            idx_d = sel;
            cnt_d = '0;
        end else if (rel) begin
            state_d = IDLE;
            gnt_d = '0;
            idx_d = 4'd15;
            cnt_d = '0;
        end
    end
    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            state_q <= IDLE;
            gnt_q <= '0;
            idx_q <= 4'd15;
            ptr_q <= '0;
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q <= gnt_d;
            idx_q <= idx_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end
    assign oGNT = gnt_q;
    assign oGNT_IDX = idx_q;
    assign oVALID = |gnt_q;
    assign oTIMEOUT = tmo_q;
endmodule

// File: tb/tb_rr_arbiter10.sv
// tb_rr_arbiter10: directed-vector bench for rr_arbiter10 with hand-computed expectations.
module tb_rr_arbiter10;
    logic iCLK = 1'b0;
    logic iRSTn;
    logic [9:0] iREQ;
    logic iDONE;
    logic [9:0] oGNT;
    logic [3:0] oGNT_IDX;
    logic oVALID;
    logic oTIMEOUT;
    int n_chk = 0;
    int n_pass = 0;

    rr_arbiter10 dut (
        .iCLK(iCLK),
        .iRSTn(iRSTn),
        .iREQ(iREQ),
        .iDONE(iDONE),
        .oGNT(oGNT),
        .oGNT_IDX(oGNT_IDX),
        .oVALID(oVALID),
        .oTIMEOUT(oTIMEOUT)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic check_out(input string tag, input int idx, input int tmo);
        check({tag, ".gnt"}, int'(oGNT), idx == 15 ? 0 : (1 << idx));
        check({tag, ".idx"}, int'(oGNT_IDX), idx);
        check({tag, ".valid"}, int'(oVALID), idx == 15 ? 0 : 1);
        check({tag, ".tmo"}, int'(oTIMEOUT), tmo);
    endtask

    initial begin
        iRSTn = 1'b0;
        iREQ = 10'h3FF;
        iDONE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("reset", 15, 0);
        end
        iRSTn = 1'b1;
        iREQ = '0;
        tick();
        check_out("idle", 15, 0);
        iREQ = 10'h010;
        tick();
        check_out("single", 4, 0);
        iDONE = 1'b1;
        tick();
        check_out("single_rel", 15, 0);
        iDONE = 1'b0;
        iREQ = '0;
        iRSTn = 1'b0;
        tick();
        iRSTn = 1'b1;
        iREQ = 10'h3FF;
        tick();
        check_out("rot0", 0, 0);
        iDONE = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("rot.idx", int'(oGNT_IDX), i % 10);
            check("rot.valid", int'(oVALID), 1);
        end
        iREQ = 10'h201;
        tick();
        check("fair9", int'(oGNT_IDX), 9);
        tick();
        check("fair0", int'(oGNT_IDX), 0);
        tick();
        check("fair9b", int'(oGNT_IDX), 9);
        tick();
        check("fair0b", int'(oGNT_IDX), 0);
        iDONE = 1'b0;
        iREQ = '0;
        tick();
        check_out("withdraw_idle", 15, 0);
        iREQ = 10'h004;
        tick();
        check_out("hold0", 2, 0);
        for (int i = 1; i < 16; i++) begin
            tick();
            check("hold.idx", int'(oGNT_IDX), 2);
            check("hold.tmo", int'(oTIMEOUT), 0);
        end
        tick();
        check_out("timeout", 15, 1);
        tick();
        check_out("regrant", 2, 0);
        for (int i = 1; i < 16; i++) tick();
        check_out("hold15", 2, 0);
        iDONE = 1'b1;
        tick();
        check_out("done_at_tmo", 15, 0);
        iREQ = '0;
        tick();
        check_out("done_idle", 15, 0);
        iDONE = 1'b0;
        iREQ = 10'h080;
        tick();
        check_out("grant7", 7, 0);
        iREQ = 10'h101;
        tick();
        check_out("ptr8", 8, 0);
        iRSTn = 1'b0;
        tick();
        check_out("rst_mid", 15, 0);
        iRSTn = 1'b1;
        iREQ = '0;
        tick();
        check_out("post_rst", 15, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rr_arbiter10.md
Name: rr_arbiter10

Overview:
- Round-robin arbiter that shares one downstream resource among 10 requesters.
- Produces a registered one-hot grant vector and its 4-bit binary index: the one-hot-to-binary path of the 10-input encoder, now sequenced by a controller.
- Includes a hold-timeout watchdog so a stuck requester cannot lock the resource.
- Sits between requester blocks and the shared datapath; the datapath is steered by oGNT_IDX.

Parameters:
- N, 10, number of requesters. Fixed at 10; other values are not supported.
- IDXW, 4, width of the grant index.
- MAXHOLD, 16, maximum cycles a grant is held before forced release. Legal range 2..255.

Ports:
- iCLK  input  1  clock, rising edge.
- iRSTn  input  1  reset, synchronous, active-low.
- iREQ  input  10  request per requester. Level; held until done.
- iDONE  input  1  one-cycle pulse from the current grant holder: release.
- oGNT  output  10  one-hot grant, registered.
- oGNT_IDX  output  4  binary index of the granted requester, 0..9. Equals 4'd15 when nothing is granted.
- oVALID  output  1  high while a grant is active.
- oTIMEOUT  output  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset (iRSTn=0 at a rising edge):
  - oGNT=0, oGNT_IDX=15, oVALID=0, oTIMEOUT=0.
  - Priority pointer PTR=0, hold counter=0, state=IDLE.
  - Reset mid-grant drops the grant at that edge, with no oTIMEOUT pulse.
- States: IDLE, GRANT.
- IDLE:
  - If iREQ!=0, select the first set bit scanning PTR, PTR+1, …, 9, 0, …, PTR-1.
  - At the next edge: oGNT = that bit, oGNT_IDX = its index, oVALID=1, counter=0, state=GRANT.
  - Latency from request seen in IDLE to grant: 1 clock.
- GRANT: a release condition occurs in any cycle where at least one of the following holds:
  - (a) iDONE=1.
  - (b) iREQ[oGNT_IDX]=0, i.e. the requester withdrew.
  - (c) counter reaches MAXHOLD-1. This is a timeout; oTIMEOUT=1 for exactly one cycle, coincident with the release edge output.
- On release:
  - PTR = granted index + 1, wrapping 9→0.
  - Next grant is computed combinationally from the current iREQ, with the granted bit masked and the new PTR. This gives back-to-back grants: the new grant appears at the same edge that drops the old one.
  - If no other request is pending, the outputs return to the IDLE values and state=IDLE.
- Counter increments every cycle in GRANT and clears on each new grant.
- Simultaneous events:
  - iDONE together with a timeout: treated as a normal release; oTIMEOUT stays 0.
  - iDONE while in IDLE: ignored.
  - A requester that is released with its iREQ still high is eligible again only after every other pending requester has had its turn.
- Invariants:
  - oGNT is always zero or one-hot.
  - oGNT_IDX always matches oGNT.
  - oVALID == |oGNT.
  - No grant is issued to a bit that has iREQ=0.

Test Plan:
- Reset check: hold iRSTn=0 for 3 clocks with iREQ=10'h3FF → oGNT=0, oGNT_IDX=15, oVALID=0 throughout.
- Single requester: iREQ=10'b00_0001_0000 → 1 clock later oGNT=10'h010, oGNT_IDX=4. iDONE pulse → next edge oGNT=0, oGNT_IDX=15.
- Rotation: iREQ=10'h3FF, pulse iDONE 10 times → grant indices 0,1,2,…,9 with no idle cycle between them, then 0 again (wrap).
- Fairness/pointer: after a grant to 9, iREQ=10'b10_0000_0001 → next grant index 0, then 9, alternating.
- Timeout: MAXHOLD=16, iREQ=10'h004 held, no iDONE → oGNT_IDX=2 for 16 cycles, then oTIMEOUT=1 for 1 cycle. Grant to 2 is re-issued with the same behaviour, since no other requester is pending.
- Withdraw and reset mid-grant:
  - While granted to 7, drop iREQ[7] → release at the next edge, PTR=8.
  - Separately, assert iRSTn=0 during a grant → next edge all outputs at reset values, oTIMEOUT=0.
